// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - beat tags, FSM state type and tag helpers for pkt_tx_arbiter
package pkt_arb_pkg;

  localparam int BEAT_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b11;
  localparam logic [1:0] TAG_BODY = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic logic is_head(input logic [BEAT_W-1:0] beat);
    return beat[BEAT_W-1 -: 2] == TAG_HEAD;
  endfunction

  function automatic logic is_tail(input logic [BEAT_W-1:0] beat);
    return beat[BEAT_W-1 -: 2] == TAG_TAIL;
  endfunction

endpackage

// File: rtl/pkt_tx_arbiter_rr_pick.sv
// rtl/pkt_tx_arbiter_rr_pick.sv - combinational first-set search starting at a rotating pointer
module rr_pick #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % N]) begin
        o_any                              = 1'b1;
        o_idx                              = IW'((int'(i_ptr) + i) % N);
        o_onehot[(int'(i_ptr) + i) % N]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// rtl/pkt_tx_arbiter.sv - packet-granular round-robin merge of N beat streams onto one egress
module pkt_tx_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int N_PORT      = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_PORT-1:0]         i_req_valid,
  input  logic [N_PORT*BEAT_W-1:0]  i_req_data,
  output logic [N_PORT-1:0]         o_req_ready,
  output logic                      o_data_valid,
  output logic [BEAT_W-1:0]         o_data,
  input  logic                      i_alf,
  output logic [N_PORT*CNT_W-1:0]   o_pkt_cnt,
  output logic [N_PORT*CNT_W-1:0]   o_drop_cnt,
  output logic [N_PORT-1:0]         o_err,
  input  logic                      i_err_clr
);

  localparam int IW = $clog2(N_PORT);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic [N_PORT-1:0]   err_q, err_d, err_set;
  logic [CNT_W-1:0]    pkt_cnt_q [N_PORT];
  logic [CNT_W-1:0]    pkt_cnt_d [N_PORT];
  logic [CNT_W-1:0]    drop_cnt_q [N_PORT];
  logic [CNT_W-1:0]    drop_cnt_d [N_PORT];

  logic [BEAT_W-1:0]   beat [N_PORT];
  logic [N_PORT-1:0]   eligible, win_oh, ready;
  logic [IW-1:0]       win_idx;
  logic                win_any;

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      beat[p]     = i_req_data[p*BEAT_W +: BEAT_W];
      eligible[p] = i_req_valid[p] && is_head(beat[p]);
    end
  end

  rr_pick #(.N(N_PORT)) u_pick (
    .i_req    (eligible),
    .i_ptr    (rr_ptr_q),
    .o_onehot (win_oh),
    .o_idx    (win_idx),
    .o_any    (win_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    stall_d     = stall_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_set     = '0;
    ready       = '0;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    // Non-head beats outside the locked packet are swallowed so a broken source cannot wedge.
    for (int p = 0; p < N_PORT; p++) begin
      if (i_req_valid[p] && !is_head(beat[p]) &&
          !(state_q == LOCK && grant_q == IW'(p))) begin
        ready[p] = 1'b1;
        if (drop_cnt_q[p] != '1) drop_cnt_d[p] = drop_cnt_q[p] + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!i_alf && win_any) begin
          ready       = ready | win_oh;
          out_valid_d = 1'b1;
          out_data_d  = beat[win_idx];
          grant_d     = win_idx;
          rr_ptr_d    = (win_idx == IW'(N_PORT - 1)) ? '0 : win_idx + 1'b1;
          stall_d     = '0;
          state_d     = LOCK;
        end
      end
      LOCK: begin
        ready[grant_q] = 1'b1;
        if (i_req_valid[grant_q]) begin
          out_valid_d = 1'b1;
          out_data_d  = beat[grant_q];
          stall_d     = '0;
          if (is_tail(beat[grant_q])) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 1'b1;
            state_d            = IDLE;
          end
        end else if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
          // Close the packet downstream so the MAC never sees an unterminated frame.
          out_valid_d       = 1'b1;
          out_data_d        = {TAG_TAIL, {(BEAT_W-2){1'b0}}};
          err_set[grant_q]  = 1'b1;
          stall_d           = '0;
          state_d           = IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = (err_q & ~{N_PORT{i_err_clr}}) | err_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      stall_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= '0;
      for (int p = 0; p < N_PORT; p++) begin
        pkt_cnt_q[p]  <= '0;
        drop_cnt_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_req_ready  = ready;
  assign o_data_valid = out_valid_q;
  assign o_data       = out_data_q;
  assign o_err        = err_q;

  for (genvar p = 0; p < N_PORT; p++) begin : g_cnt
    assign o_pkt_cnt[p*CNT_W +: CNT_W]  = pkt_cnt_q[p];
    assign o_drop_cnt[p*CNT_W +: CNT_W] = drop_cnt_q[p];
  end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// tb/tb_pkt_tx_arbiter.sv - scoreboard bench for pkt_tx_arbiter with a packet-level reference model
module tb_pkt_tx_arbiter;
  import pkt_arb_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 32;
  localparam int CW  = 32;
  localparam int BW  = 134;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [N-1:0]      i_req_valid;
  logic [N*BW-1:0]   i_req_data;
  logic [N-1:0]      o_req_ready;
  logic              o_data_valid;
  logic [BW-1:0]     o_data;
  logic              i_alf;
  logic [N*CW-1:0]   o_pkt_cnt;
  logic [N*CW-1:0]   o_drop_cnt;
  logic [N-1:0]      o_err;
  logic              i_err_clr;

  pkt_tx_arbiter #(.N_PORT(N), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_data_valid(o_data_valid), .o_data(o_data), .i_alf(i_alf),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [BW-1:0] data;
    int            due;
  } eg_t;

  eg_t           egq[$];
  logic [BW-1:0] srcq [N][$];
  int            tests = 0, fails = 0, cyc = 0;
  bit            mon_en = 1'b0;
  int            locked = -1, ptr = 0, stall = 0;
  int            exp_pkt [N];
  int            exp_drop [N];
  int            stall_left [N];
  logic [N-1:0]  exp_err = '0;
  int            vprob = 100, alf_mode = 0, clr_mode = 0;
  bit            rnd_mode = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [131:0] rnd132();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[131:0];
  endfunction

  task automatic gen_pkt(input int p, input int n);
    logic [1:0] tg;
    srcq[p].push_back({TAG_HEAD, rnd132()});
    for (int i = 0; i < n - 2; i++) begin
      tg = ($urandom_range(3) == 0) ? 2'b00 : TAG_BODY;
      srcq[p].push_back({tg, rnd132()});
    end
    srcq[p].push_back({TAG_TAIL, rnd132()});
  endtask

  // One clock: drive at negedge, predict and compare ready, commit model after posedge.
  task automatic step();
    logic [N-1:0]  v, er, n_err;
    logic [BW-1:0] b [N];
    logic [1:0]    jt;
    logic          a, clr;
    int            win, q;
    eg_t           e;
    @(negedge i_clk);
    for (int p = 0; p < N; p++) begin
      if (rnd_mode && srcq[p].size() == 0) begin
        if ($urandom_range(9) == 0) srcq[p].push_back({($urandom_range(1) == 0) ? TAG_BODY : TAG_TAIL, rnd132()});
        else gen_pkt(p, $urandom_range(2, 6));
      end
      if (rnd_mode && stall_left[p] == 0 && $urandom_range(99) == 0)
        stall_left[p] = ($urandom_range(2) == 0) ? TMO - 2 + $urandom_range(4) : $urandom_range(1, 4);
      if (stall_left[p] > 0) begin
        v[p] = 1'b0;
        stall_left[p]--;
      end else begin
        v[p] = (srcq[p].size() > 0) && ($urandom_range(99) < vprob);
      end
      jt = 2'($urandom_range(3));
      b[p] = v[p] ? srcq[p][0] : {jt, rnd132()};
      i_req_valid[p] = v[p];
      i_req_data[p*BW +: BW] = b[p];
    end
    a   = (alf_mode == 1) || (alf_mode == 2 && $urandom_range(99) < 30);
    clr = (clr_mode == 1) || (clr_mode == 2 && $urandom_range(99) < 3);
    i_alf     = a;
    i_err_clr = clr;
    #1;
    er    = '0;
    win   = -1;
    n_err = exp_err & ~{N{clr}};
    for (int p = 0; p < N; p++) begin
      if (v[p] && b[p][133:132] != TAG_HEAD && p != locked) begin
        er[p] = 1'b1;
        exp_drop[p]++;
      end
    end
    if (locked < 0) begin
      if (!a) begin
        for (int k = 0; k < N; k++) begin
          q = (ptr + k) % N;
          if (win < 0 && v[q] && b[q][133:132] == TAG_HEAD) win = q;
        end
      end
      if (win >= 0) begin
        er[win] = 1'b1;
        e.data = b[win]; e.due = cyc + 1; egq.push_back(e);
        locked = win;
        ptr    = (win + 1) % N;
        stall  = 0;
      end
    end else begin
      er[locked] = 1'b1;
      if (v[locked]) begin
        e.data = b[locked]; e.due = cyc + 1; egq.push_back(e);
        stall = 0;
        if (b[locked][133:132] == TAG_TAIL) begin
          exp_pkt[locked]++;
          locked = -1;
        end
      end else if (stall + 1 >= TMO) begin
        e.data = {TAG_TAIL, 132'h0}; e.due = cyc + 1; egq.push_back(e);
        n_err[locked] = 1'b1;
        locked = -1;
        stall  = 0;
      end else begin
        stall++;
      end
    end
    check("req_ready", BW'(o_req_ready), BW'(er));
    for (int p = 0; p < N; p++)
      if (v[p] && er[p]) void'(srcq[p].pop_front());
    @(posedge i_clk);
    #1;
    exp_err = n_err;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_counters();
    for (int p = 0; p < N; p++) begin
      check($sformatf("pkt_cnt[%0d]", p), BW'(o_pkt_cnt[p*CW +: CW]), BW'(exp_pkt[p]));
      check($sformatf("drop_cnt[%0d]", p), BW'(o_drop_cnt[p*CW +: CW]), BW'(exp_drop[p]));
    end
  endtask

  task automatic do_reset(input bit chk_zero);
    mon_en = 1'b0;
    @(negedge i_clk);
    #2;
    i_rst = 1'b1; i_req_valid = '0; i_alf = 1'b0; i_err_clr = 1'b0;
    #1;
    if (chk_zero) begin
      check("rst_data_valid", BW'(o_data_valid), BW'(1'b0));
      check("rst_data", o_data, '0);
      check("rst_req_ready", BW'(o_req_ready), '0);
      check("rst_err", BW'(o_err), '0);
      check("rst_pkt_cnt", BW'(o_pkt_cnt), '0);
      check("rst_drop_cnt", BW'(o_drop_cnt), '0);
    end
    locked = -1; ptr = 0; stall = 0; exp_err = '0;
    egq.delete();
    for (int p = 0; p < N; p++) begin
      srcq[p].delete();
      exp_pkt[p] = 0; exp_drop[p] = 0; stall_left[p] = 0;
    end
    repeat (2) @(negedge i_clk);
    i_rst  = 1'b0;
    mon_en = 1'b1;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (locked < 0);
    for (int p = 0; p < N; p++) if (srcq[p].size() != 0 || stall_left[p] != 0) r = 1'b0;
    return r;
  endfunction

  always @(negedge i_clk) begin
    #3;
    if (mon_en) begin
      if (egq.size() > 0 && egq[0].due == cyc) begin
        check("egress_valid", BW'(o_data_valid), BW'(1'b1));
        check("egress_data", o_data, egq[0].data);
        void'(egq.pop_front());
      end else begin
        check("egress_idle", BW'(o_data_valid), BW'(1'b0));
      end
      check("err_flags", BW'(o_err), BW'(exp_err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    i_req_valid = '0; i_req_data = '0; i_alf = 1'b0; i_err_clr = 1'b0;
    for (int p = 0; p < N; p++) begin
      exp_pkt[p] = 0; exp_drop[p] = 0; stall_left[p] = 0;
    end
    do_reset(1'b1);

    srcq[0].push_back({TAG_HEAD, rnd132()});
    srcq[0].push_back({TAG_BODY, rnd132()});
    srcq[0].push_back({TAG_BODY, rnd132()});
    srcq[0].push_back({TAG_TAIL, rnd132()});
    run(8);
    check_counters();
    check("single_pkt_cnt0", BW'(o_pkt_cnt[CW-1:0]), BW'(1));

    do_reset(1'b0);
    for (int p = 0; p < N; p++) gen_pkt(p, 3);
    run(16);
    gen_pkt(0, 3);
    gen_pkt(1, 3);
    run(12);
    check_counters();

    alf_mode = 1;
    gen_pkt(0, 3);
    run(10);
    alf_mode = 0;
    run(6);
    gen_pkt(1, 6);
    run(2);
    alf_mode = 1;
    run(8);
    alf_mode = 0;
    check_counters();

    do_reset(1'b0);
    srcq[1].push_back({TAG_BODY, rnd132()});
    run(4);
    check("orphan_drop1", BW'(o_drop_cnt[CW +: CW]), BW'(1));
    check_counters();

    srcq[2].push_back({TAG_HEAD, rnd132()});
    srcq[2].push_back({TAG_BODY, rnd132()});
    run(3);
    stall_left[2] = TMO + 4;
    srcq[2].push_back({TAG_BODY, rnd132()});
    srcq[2].push_back({TAG_TAIL, rnd132()});
    gen_pkt(0, 3);
    run(TMO + 12);
    check("timeout_err", BW'(o_err), BW'(3'b100));
    clr_mode = 1;
    step();
    clr_mode = 0;
    step();
    check("err_cleared", BW'(o_err), '0);
    check_counters();

    do_reset(1'b0);
    gen_pkt(1, 8);
    run(3);
    do_reset(1'b1);
    gen_pkt(0, 3);
    gen_pkt(1, 3);
    run(12);
    check("post_rst_pkt0", BW'(o_pkt_cnt[CW-1:0]), BW'(1));
    check_counters();

    do_reset(1'b0);
    rnd_mode = 1'b1; vprob = 70; alf_mode = 2; clr_mode = 2;
    run(4000);
    rnd_mode = 1'b0; vprob = 100; alf_mode = 0; clr_mode = 0;
    for (int p = 0; p < N; p++) stall_left[p] = 0;
    for (int g = 0; g < 600 && !all_idle(); g++) step();
    tests++;
    if (!all_idle()) begin
      fails++;
      $display("FAIL drain: sources still busy after cycle budget, locked port %0d expected none", locked);
    end
    run(3);
    check_counters();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
